// File: rtl/maze_pkg.sv
// Shared maze geometry and wall-query arbiter state encoding.
package maze_pkg;
  localparam int unsigned MAZE_COLS = 50;
  localparam int unsigned MAZE_ROWS = 56;
  localparam int unsigned ADDR_W    = 12;

  typedef enum logic [1:0] {IDLE, READ, RESP} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: first set request at or after i_start, wrapping modulo NUM_REQ.
module rr_pick
  import maze_pkg::*;
#(
  parameter int unsigned NUM_REQ = 5,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_start,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_found
);

  logic [IDX_W:0] w_pos;

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_pos   = '0;
    // Scan farthest-first so the nearest requester after i_start is the last to overwrite.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = {1'b0, i_start} + (IDX_W + 1)'(k);
      if (w_pos >= (IDX_W + 1)'(NUM_REQ)) begin
        w_pos = w_pos - (IDX_W + 1)'(NUM_REQ);
      end
      if (i_req[w_pos[IDX_W-1:0]]) begin
        o_idx   = w_pos[IDX_W-1:0];
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/maze_arbiter.sv
// Arbitrates wall queries from Pac-Man and ghosts onto one maze wall ROM.
// Define PACMAN_PRIORITY_EN to give requester 0 absolute priority over the ghosts.
module maze_arbiter
  import maze_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 5,
  parameter int unsigned TILE_SHIFT = 3
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*10-1:0]   req_x,
  input  logic [NUM_REQ*10-1:0]   req_y,
  output logic                    mem_rd,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_rdata,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic                    rsp_wall,
  output logic                    busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_t         r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ptr, r_win;
  logic               r_oob;
  logic [IDX_W-1:0]   w_pick, w_win, w_ptr_nxt;
  logic               w_found, w_grant, w_adv, w_oob;
  logic [NUM_REQ-1:0] w_rr_req;
  logic [9:0]         w_x, w_y, w_col, w_row;
  logic [ADDR_W-1:0]  w_addr;

`ifdef PACMAN_PRIORITY_EN
  // Pac-Man bypasses the rotation; the pointer only tracks the ghosts.
  assign w_rr_req = req & ~NUM_REQ'(1);
  assign w_win    = req[0] ? '0 : w_pick;
  assign w_grant  = req[0] | w_found;
  assign w_adv    = ~req[0];
`else
  assign w_rr_req = req;
  assign w_win    = w_pick;
  assign w_grant  = w_found;
  assign w_adv    = 1'b1;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req   (w_rr_req),
    .i_start (r_ptr),
    .o_idx   (w_pick),
    .o_found (w_found)
  );

  assign w_x       = req_x[int'(w_win)*10 +: 10];
  assign w_y       = req_y[int'(w_win)*10 +: 10];
  assign w_col     = w_x >> TILE_SHIFT;
  assign w_row     = w_y >> TILE_SHIFT;
  assign w_oob     = (32'(w_col) >= MAZE_COLS) || (32'(w_row) >= MAZE_ROWS);
  assign w_addr    = ADDR_W'(32'(w_row) * MAZE_COLS + 32'(w_col));
  assign w_ptr_nxt = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_grant) w_state_nxt = READ;
      READ:    w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ptr     <= '0;
      r_win     <= '0;
      r_oob     <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      rsp_valid <= '0;
      rsp_wall  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_rd    <= 1'b0;
      rsp_valid <= '0;
      busy      <= (w_state_nxt != IDLE);
      if (r_state == IDLE && w_grant) begin
        r_win    <= w_win;
        r_oob    <= w_oob;
        mem_addr <= w_addr;
        mem_rd   <= ~w_oob;
        if (w_adv) r_ptr <= w_ptr_nxt;
      end
      if (r_state == RESP) begin
        rsp_wall  <= r_oob | mem_rdata;
        rsp_valid <= NUM_REQ'(1) << r_win;
      end
    end
  end

endmodule

// File: doc/maze_arbiter.md
MAZE_ARBITER -- requirements
Module: maze_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 5, is the number of wall-query requesters (index 0 is Pac-Man, 1-4 are ghosts).
REQ-002 Parameter TILE_SHIFT, default 3, is log2 of the tile edge in pixels.
REQ-003 Port Clk, input, 1, is the single system clock; every register is clocked on its rising edge.
REQ-004 Port Reset, input, 1, is the asynchronous active-high reset.
REQ-005 Port req, input, NUM_REQ, holds one query request per requester; the requester holds it high until its rsp_valid.
REQ-006 Port req_x, input, NUM_REQ*10, carries the packed pixel X per requester (requester i at bits [10i+9:10i]).
REQ-007 Port req_y, input, NUM_REQ*10, carries the packed pixel Y per requester, packed the same way.
REQ-008 Port mem_rd, output, 1, is the single-port maze wall ROM read strobe.
REQ-009 Port mem_addr, output, 12, is the ROM tile address.
REQ-010 Port mem_rdata, input, 1, is the ROM wall bit, valid the cycle after mem_rd.
REQ-011 Port rsp_valid, output, NUM_REQ, is a one-cycle response pulse to the served requester.
REQ-012 Port rsp_wall, output, 1, is the wall result, qualified by rsp_valid.
REQ-013 Port busy, output, 1, is high whenever the FSM is not IDLE.

Function
REQ-014 The FSM shall have the states IDLE, READ and RESP; all outputs shall be registered.
REQ-015 IDLE with any req bit high shall select a winner, latch its index and tile, and go to READ; with no req high it shall stay in IDLE.
REQ-016 Tile math: col = x >> TILE_SHIFT, row = y >> TILE_SHIFT, mem_addr = row*MAZE_COLS + col, truncated to 12 bits.
REQ-017 READ shall assert mem_rd for exactly one cycle with mem_addr stable, then go to RESP.
REQ-018 If col >= MAZE_COLS or row >= MAZE_ROWS, READ shall keep mem_rd low and the response shall force rsp_wall = 1.
REQ-019 RESP shall capture mem_rdata (or the forced 1), pulse rsp_valid[winner] in the next cycle, and return to IDLE.
REQ-020 Latency is fixed: req sampled at edge 0 gives mem_rd in cycle 1 and rsp_valid in cycle 3; the minimum spacing between grants is 3 cycles.
REQ-021 Round-robin: the search starts at (last winner + 1) mod NUM_REQ and the lowest index at or after that start wins.
REQ-022 Pointer update: the pointer shall advance only when a grant is made.
REQ-023 Dropped request: if req drops before it is selected, no response shall be issued.
REQ-024 Committed request: once a requester is selected, its response shall be delivered even if req drops.
REQ-025 At most one rsp_valid bit shall be high in any cycle; rsp_wall shall hold its value between pulses.

Reset
REQ-026 Reset shall force state = IDLE, pointer = 0, mem_rd = 0, mem_addr = 0, rsp_valid = 0, rsp_wall = 0 and busy = 0.
REQ-027 A reset during READ or RESP shall abandon the query with no rsp_valid, and requests shall be re-arbitrated from index 0 after reset is released.

Configuration
REQ-028 Macro PACMAN_PRIORITY_EN: when it is defined, requester 0 shall win whenever req[0] is high and the round-robin shall cover only indices 1..NUM_REQ-1.
REQ-029 Without PACMAN_PRIORITY_EN, all requesters shall share pure round-robin per REQ-021.

Structure
REQ-030 Package maze_pkg shall hold MAZE_COLS = 50, MAZE_ROWS = 56, ADDR_W = 12 and the arb_state_t enum {IDLE, READ, RESP}.
REQ-031 The winner search shall be a sub-module rr_pick (inputs: request vector and start index; outputs: winner index and found flag).

Verification
REQ-032 Single request: req = 00001 with x=202, y=253 -> mem_rd in cycle 1 with mem_addr = 31*50+25 = 1575; mem_rdata = 0 -> rsp_valid = 00001 and rsp_wall = 0 in cycle 3.
REQ-033 All requesting, macro off: req = 11111 held -> grant order 0,1,2,3,4,0, with rsp_valid pulses exactly 3 cycles apart.
REQ-034 All requesting, macro on: req = 11111 held -> requester 0 is served every grant and the others are starved; after req[0] drops, the order is 1,2,3,4.
REQ-035 Out of range: x = 500 -> mem_rd stays low and rsp_wall = 1 in cycle 3.
REQ-036 Reset mid-query: Reset pulses in RESP -> no rsp_valid, all outputs 0, and the next grant goes to the lowest requesting index.
REQ-037 Early drop: req[2] drops one cycle after its grant -> rsp_valid[2] still pulses in cycle 3.
